// File: rtl/cm_arb_dispatch.sv
// cm_arb_dispatch: drives cm_arbiter requests and connects the granted source to one output stream per packet.
// Optional: define CM_ARB_DISPATCH_BURST_LIMIT_EN to end every MAX_BEATS-th beat as a burst and re-arbitrate.

module cm_arb_dispatch_chk #(
    parameter int DCNT      = 4,
    parameter int MAX_BEATS = 16
) (
    input logic clk_i,
    input logic rst_i,
    input logic xfer_i,
    input logic arb_vld_i
);
    // A result arriving mid-packet means the request mask was bypassed upstream.
    gnt_in_xfer: assert property (@(posedge clk_i) disable iff (rst_i) !(xfer_i && arb_vld_i));
    param_legal: assert property (@(posedge clk_i) (DCNT >= 2) && (MAX_BEATS >= 1));
endmodule

module cm_arb_dispatch #(
    parameter int  DCNT      = 4,
    parameter int  DWIDTH    = 32,
    parameter int  MAX_BEATS = 16,
    localparam int IDX_WIDTH = $clog2(DCNT)
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    output logic [DCNT-1:0]              o_req,
    input  logic                         i_arb_vld,
    input  logic [IDX_WIDTH-1:0]         i_arb_gnt,
    input  logic [DCNT-1:0]              i_src_vld,
    input  logic [DCNT-1:0][DWIDTH-1:0]  i_src_data,
    input  logic [DCNT-1:0]              i_src_last,
    output logic [DCNT-1:0]              o_src_rdy,
    output logic                         o_vld,
    output logic [DWIDTH-1:0]            o_data,
    output logic                         o_last,
    input  logic                         i_rdy,
    output logic [IDX_WIDTH-1:0]         o_idx,
    output logic                         o_busy
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_XFER = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_WIDTH-1:0] gnt_q, gnt_d;
    logic                 xfer_s;
    logic                 last_s;
    logic                 accept_s;
    logic                 burst_end_s;

`ifdef CM_ARB_DISPATCH_BURST_LIMIT_EN
    localparam int                BEAT_W    = $clog2(MAX_BEATS) + 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(MAX_BEATS - 1);

    logic [BEAT_W-1:0] beat_q, beat_d;

    assign burst_end_s = (beat_q == BEAT_LAST);

    // Beat counter: counts accepted beats of the current burst, zero outside XFER.
    always_comb begin
        beat_d = beat_q;
        if (!xfer_s) begin
            beat_d = '0;
        end else if (accept_s) begin
            beat_d = last_s ? '0 : (beat_q + BEAT_W'(1));
        end else begin
            beat_d = beat_q;
        end
    end

    // Beat counter register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            beat_q <= '0;
        end else begin
            beat_q <= beat_d;
        end
    end
`else
    assign burst_end_s = 1'b0;
`endif

    assign xfer_s   = (state_q == ST_XFER);
    assign last_s   = i_src_last[gnt_q] | burst_end_s;
    assign accept_s = xfer_s & i_src_vld[gnt_q] & i_rdy;

    // Output mux: zero-latency path from the granted source, everything forced low in reset.
    always_comb begin
        o_req     = '0;
        o_src_rdy = '0;
        o_vld     = 1'b0;
        o_data    = '0;
        o_last    = 1'b0;
        o_idx     = '0;
        o_busy    = 1'b0;
        if (!i_rst) begin
            o_req            = (state_q == ST_IDLE) ? i_src_vld : '0;
            o_src_rdy[gnt_q] = xfer_s & i_rdy;
            o_vld            = xfer_s & i_src_vld[gnt_q];
            o_data           = xfer_s ? i_src_data[gnt_q] : '0;
            o_last           = xfer_s & last_s;
            o_idx            = gnt_q;
            o_busy           = (state_q != ST_IDLE);
        end else begin
            o_req = '0;
        end
    end

    // Next state: one outstanding arbitration at a time, connection held until the last beat.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        case (state_q)
            ST_IDLE: begin
                if (i_arb_vld) begin
                    gnt_d   = i_arb_gnt;
                    state_d = ST_XFER;
                end else if (|i_src_vld) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (i_arb_vld) begin
                    gnt_d   = i_arb_gnt;
                    state_d = ST_XFER;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_XFER: begin
                if (accept_s && last_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_XFER;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // State and grant registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
        end
    end

    cm_arb_dispatch_chk #(
        .DCNT      (DCNT),
        .MAX_BEATS (MAX_BEATS)
    ) u_chk (
        .clk_i     (i_clk),
        .rst_i     (i_rst),
        .xfer_i    (xfer_s),
        .arb_vld_i (i_arb_vld)
    );
endmodule

// File: tb/tb_cm_arb_dispatch.sv
// Self-checking bench for cm_arb_dispatch: bench-side arbiter with programmable latency,
// packet-queue sources and a connection-level reference model.

module tb_cm_arb_dispatch;
    localparam int DCNT   = 4;
    localparam int DWIDTH = 32;
    localparam int MAXB   = 4;
    localparam int IW     = 2;
`ifdef CM_ARB_DISPATCH_BURST_LIMIT_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic                        clk = 1'b0;
    logic                        i_rst, i_arb_vld, i_rdy;
    logic [IW-1:0]               i_arb_gnt;
    logic [DCNT-1:0]             i_src_vld, i_src_last;
    logic [DCNT-1:0][DWIDTH-1:0] i_src_data;
    logic [DCNT-1:0]             o_req, o_src_rdy;
    logic                        o_vld, o_last, o_busy;
    logic [DWIDTH-1:0]           o_data;
    logic [IW-1:0]               o_idx;

    always #5 clk = ~clk;

    cm_arb_dispatch #(.DCNT(DCNT), .DWIDTH(DWIDTH), .MAX_BEATS(MAXB)) dut (
        .i_clk(clk), .i_rst(i_rst), .o_req(o_req), .i_arb_vld(i_arb_vld), .i_arb_gnt(i_arb_gnt),
        .i_src_vld(i_src_vld), .i_src_data(i_src_data), .i_src_last(i_src_last),
        .o_src_rdy(o_src_rdy), .o_vld(o_vld), .o_data(o_data), .o_last(o_last),
        .i_rdy(i_rdy), .o_idx(o_idx), .o_busy(o_busy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int regcnt   = 2;
    bit pick_high = 1'b0;

    // source packet stores: {last, data}
    logic [DWIDTH:0] mem [DCNT][256];
    int              hd  [DCNT];
    int              tl  [DCNT];
    logic [DCNT-1:0] pres = '0;

    int arb_fire = -1;
    int arb_pick = 0;
    int n_grants = 0;

    // reference model: connection-level view of the dispatcher
    bit m_conn = 1'b0;
    bit m_wait = 1'b0;
    int m_idx  = 0;
    int m_beats = 0;

    logic [DCNT-1:0]   exp_req, exp_rdy;
    logic              exp_vld, exp_last, exp_busy;
    logic [DWIDTH-1:0] exp_data;
    logic [IW-1:0]     exp_idx;

    logic [DCNT-1:0]   s_req, s_rdy, s_src_vld;
    logic              s_vld, s_last, s_busy;
    logic [DWIDTH-1:0] s_data;
    logic [IW-1:0]     s_idx;
    bit                acc_now;
    int                acc_total = 0;
    int                acc_lasts = 0;

    function automatic bit all_done();
        bit d = !m_conn && !m_wait && (pres == '0);
        for (int s = 0; s < DCNT; s++) if (hd[s] != tl[s]) d = 1'b0;
        return d;
    endfunction

    task automatic push_pkt(input int s, input int len);
        if (hd[s] == tl[s]) begin hd[s] = 0; tl[s] = 0; end
        for (int k = 0; k < len; k++) begin
            mem[s][tl[s]] = {(k == len - 1), $urandom()};
            tl[s]++;
        end
    endtask

    // One clock: drive sources, play the arbiter, score every output against the model, advance.
    task automatic cycle(input bit rst, input int rdy_pct, input int pres_pct);
        logic [DWIDTH:0] beat;
        @(negedge clk);
        i_rst = rst;
        i_rdy = ($urandom_range(99) < rdy_pct);
        for (int s = 0; s < DCNT; s++) begin
            if (!pres[s] && hd[s] != tl[s] && $urandom_range(99) < pres_pct) pres[s] = 1'b1;
            beat = mem[s][hd[s]];
            i_src_vld[s]  = pres[s];
            i_src_data[s] = pres[s] ? beat[DWIDTH-1:0] : $urandom();
            i_src_last[s] = pres[s] ? beat[DWIDTH] : 1'($urandom());
        end
        #1;
        if (!rst && o_req != '0 && arb_fire < 0) begin
            arb_pick = -1;
            if (pick_high) begin
                for (int s = 0; s < DCNT; s++) if (o_req[s]) arb_pick = s;
            end else begin
                for (int t = 0; t < 64 && arb_pick < 0; t++) begin
                    int r = $urandom_range(DCNT - 1);
                    if (o_req[r]) arb_pick = r;
                end
                for (int s = 0; s < DCNT && arb_pick < 0; s++) if (o_req[s]) arb_pick = s;
            end
            arb_fire = cyc + regcnt;
        end
        i_arb_vld = !rst && (arb_fire == cyc);
        i_arb_gnt = i_arb_vld ? IW'(arb_pick) : IW'($urandom());
        #1;
        exp_req  = (!rst && !m_conn && !m_wait) ? i_src_vld : '0;
        exp_vld  = !rst && m_conn && i_src_vld[m_idx];
        exp_data = (!rst && m_conn) ? i_src_data[m_idx] : '0;
        exp_last = !rst && m_conn && (i_src_last[m_idx] || (BURST && m_beats == MAXB - 1));
        exp_rdy  = (!rst && m_conn && i_rdy) ? (DCNT'(1) << m_idx) : '0;
        exp_idx  = rst ? '0 : IW'(m_idx);
        exp_busy = !rst && (m_conn || m_wait);

        n_checks++; if (o_req !== exp_req) begin n_fail++; $display("FAIL req cyc=%0d got=%b exp=%b", cyc, o_req, exp_req); end
        n_checks++; if (o_vld !== exp_vld) begin n_fail++; $display("FAIL vld cyc=%0d got=%b exp=%b", cyc, o_vld, exp_vld); end
        n_checks++; if (o_data !== exp_data) begin n_fail++; $display("FAIL data cyc=%0d got=%h exp=%h", cyc, o_data, exp_data); end
        n_checks++; if (o_last !== exp_last) begin n_fail++; $display("FAIL last cyc=%0d got=%b exp=%b", cyc, o_last, exp_last); end
        n_checks++; if (o_src_rdy !== exp_rdy) begin n_fail++; $display("FAIL src_rdy cyc=%0d got=%b exp=%b", cyc, o_src_rdy, exp_rdy); end
        n_checks++; if (o_idx !== exp_idx) begin n_fail++; $display("FAIL idx cyc=%0d got=%0d exp=%0d", cyc, o_idx, exp_idx); end
        n_checks++; if (o_busy !== exp_busy) begin n_fail++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, o_busy, exp_busy); end

        s_req = o_req; s_rdy = o_src_rdy; s_src_vld = i_src_vld; s_vld = o_vld;
        s_last = o_last; s_busy = o_busy; s_data = o_data; s_idx = o_idx;
        acc_now = o_vld && i_rdy;
        if (acc_now) begin acc_total++; if (o_last) acc_lasts++; end
        if (i_arb_vld) n_grants++;

        @(posedge clk);
        if (rst) begin
            m_conn = 1'b0; m_wait = 1'b0; m_idx = 0; m_beats = 0; arb_fire = -1;
        end else if (m_conn) begin
            if (exp_vld && i_rdy) begin
                m_beats++;
                if (exp_last) begin m_conn = 1'b0; m_beats = 0; end
            end
        end else if (i_arb_vld) begin
            m_conn = 1'b1; m_wait = 1'b0; m_idx = arb_pick; m_beats = 0;
        end else if (exp_req != '0) begin
            m_wait = 1'b1;
        end
        if (i_arb_vld) arb_fire = -1;
        for (int s = 0; s < DCNT; s++) if (pres[s] && s_rdy[s]) begin hd[s]++; pres[s] = 1'b0; end
        cyc++;
    endtask

    task automatic drain(input int maxc, input int rdy_pct, input int pres_pct);
        int n = 0;
        while (!all_done() && n < maxc) begin cycle(1'b0, rdy_pct, pres_pct); n++; end
        n_checks++;
        if (!all_done()) begin n_fail++; $display("FAIL drain_timeout cyc=%0d got=busy exp=idle within %0d", cyc, maxc); end
    endtask

    task automatic test_reset();
        push_pkt(0, 2); push_pkt(1, 3);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 100, 100);
            n_checks++;
            if ({s_req, s_rdy, s_vld, s_data, s_last, s_idx, s_busy} !== '0) begin
                n_fail++; $display("FAIL reset_outputs got req=%b vld=%b busy=%b exp=0", s_req, s_vld, s_busy);
            end
        end
        cycle(1'b0, 100, 100);
        n_checks++;
        if (s_req !== 4'b0011) begin n_fail++; $display("FAIL reset_release_req got=%b exp=0011", s_req); end
        drain(200, 100, 100);
    endtask

    task automatic test_single_src();
        int first_vld = -1;
        regcnt = 2; pick_high = 1'b0;
        push_pkt(2, 3);
        for (int k = 0; k < 8; k++) begin
            cycle(1'b0, 100, 100);
            if (k == 0) begin n_checks++; if (s_req !== 4'b0100) begin n_fail++; $display("FAIL single_req0 got=%b exp=0100", s_req); end end
            if (k == 1) begin n_checks++; if (s_req !== 4'b0000) begin n_fail++; $display("FAIL single_req1 got=%b exp=0000", s_req); end end
            if (s_vld && first_vld < 0) first_vld = k;
            if (k == 3) begin n_checks++; if (s_idx !== 2'd2) begin n_fail++; $display("FAIL single_idx got=%0d exp=2", s_idx); end end
            if (k == 5) begin n_checks++; if (s_last !== 1'b1 || s_busy !== 1'b1) begin n_fail++; $display("FAIL single_last got=%b exp=1", s_last); end end
            if (k == 6) begin n_checks++; if (s_busy !== 1'b0) begin n_fail++; $display("FAIL single_idle6 got=%b exp=0", s_busy); end end
        end
        n_checks++;
        if (first_vld != 3) begin n_fail++; $display("FAIL single_first_vld got=%0d exp=3", first_vld); end
    endtask

    task automatic test_two_src();
        int k = 0; int l_cyc = -1; int f_cyc = -1; int first_idx = -1; int viol = 0;
        regcnt = 2; pick_high = 1'b1;
        push_pkt(0, 2); push_pkt(3, 3);
        while (!all_done() && k < 60) begin
            cycle(1'b0, 100, 100);
            if (s_vld && first_idx < 0) first_idx = s_idx;
            if (l_cyc < 0 && s_rdy[0]) viol++;
            if (acc_now && s_last && s_idx == 2'd3 && l_cyc < 0) l_cyc = k;
            if (s_vld && s_idx == 2'd0 && f_cyc < 0) f_cyc = k;
            k++;
        end
        n_checks++; if (first_idx != 3) begin n_fail++; $display("FAIL two_first_idx got=%0d exp=3", first_idx); end
        n_checks++; if (viol != 0) begin n_fail++; $display("FAIL two_src0_rdy got=%0d exp=0", viol); end
        n_checks++;
        if (l_cyc < 0 || f_cyc < 0 || f_cyc - l_cyc - 1 != 1 + regcnt) begin
            n_fail++; $display("FAIL two_gap got=%0d exp=%0d", f_cyc - l_cyc - 1, 1 + regcnt);
        end
        pick_high = 1'b0;
    endtask

    task automatic test_stall();
        int base; int k = 0; logic [DWIDTH-1:0] d0;
        regcnt = 1;
        base = acc_total;
        push_pkt(1, 4);
        while (acc_total - base < 1 && k < 30) begin cycle(1'b0, 100, 100); k++; end
        for (int j = 0; j < 5; j++) begin
            cycle(1'b0, 0, 100);
            if (j == 0) d0 = s_data;
            n_checks++;
            if (s_vld !== 1'b1 || s_data !== d0 || s_rdy !== '0) begin
                n_fail++; $display("FAIL stall j=%0d got vld=%b data=%h rdy=%b exp vld=1 data=%h rdy=0", j, s_vld, s_data, s_rdy, d0);
            end
        end
        n_checks++; if (acc_total - base != 1) begin n_fail++; $display("FAIL stall_count got=%0d exp=1", acc_total - base); end
        drain(100, 100, 100);
        n_checks++; if (acc_total - base != 4) begin n_fail++; $display("FAIL stall_total got=%0d exp=4", acc_total - base); end
    endtask

    task automatic test_reset_mid();
        int base; int k = 0;
        regcnt = 1;
        base = acc_total;
        push_pkt(0, 4);
        while (acc_total - base < 1 && k < 30) begin cycle(1'b0, 100, 100); k++; end
        cycle(1'b1, 100, 100);
        n_checks++;
        if ({s_req, s_rdy, s_vld, s_data, s_last, s_idx, s_busy} !== '0) begin
            n_fail++; $display("FAIL midrst_outputs got vld=%b rdy=%b busy=%b exp=0", s_vld, s_rdy, s_busy);
        end
        cycle(1'b0, 100, 100);
        n_checks++;
        if (s_req !== 4'b0001 || s_vld !== 1'b0) begin n_fail++; $display("FAIL midrst_idle got req=%b vld=%b exp req=0001 vld=0", s_req, s_vld); end
        drain(100, 100, 100);
    endtask

    task automatic test_regcnt0();
        regcnt = 0;
        push_pkt(3, 2);
        cycle(1'b0, 100, 100);
        n_checks++;
        if (s_busy !== 1'b0 || s_req !== 4'b1000 || s_vld !== 1'b0) begin
            n_fail++; $display("FAIL rc0_cyc0 got busy=%b req=%b vld=%b exp 0/1000/0", s_busy, s_req, s_vld);
        end
        cycle(1'b0, 100, 100);
        n_checks++;
        if (!acc_now || s_idx !== 2'd3) begin n_fail++; $display("FAIL rc0_first_beat got acc=%b idx=%0d exp acc=1 idx=3", acc_now, s_idx); end
        drain(100, 100, 100);
    endtask

    task automatic test_burst();
        int b_acc; int b_last; int b_gnt;
        int exp_n = BURST ? 5 : 1;
        regcnt = 1;
        b_acc = acc_total; b_last = acc_lasts; b_gnt = n_grants;
        push_pkt(1, 20);
        drain(300, 100, 100);
        n_checks++; if (acc_total - b_acc != 20) begin n_fail++; $display("FAIL burst_beats got=%0d exp=20", acc_total - b_acc); end
        n_checks++; if (acc_lasts - b_last != exp_n) begin n_fail++; $display("FAIL burst_lasts got=%0d exp=%0d", acc_lasts - b_last, exp_n); end
        n_checks++; if (n_grants - b_gnt != exp_n) begin n_fail++; $display("FAIL burst_grants got=%0d exp=%0d", n_grants - b_gnt, exp_n); end
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            regcnt = $urandom_range(3);
            pick_high = 1'($urandom_range(1));
            for (int s = 0; s < DCNT; s++) begin
                int np = $urandom_range(3);
                for (int p = 0; p < np; p++) push_pkt(s, $urandom_range(1, 6));
            end
            drain(3000, 75, 60);
        end
    endtask

    initial begin
        i_rst = 1'b1; i_arb_vld = 1'b0; i_arb_gnt = '0; i_rdy = 1'b0;
        i_src_vld = '0; i_src_last = '0; i_src_data = '0;
        test_reset();
        test_single_src();
        test_two_src();
        test_stall();
        test_reset_mid();
        test_regcnt0();
        test_burst();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
